// File: rtl/dsp_pkg.sv
// Purpose: shared sizes and helpers for the voice interpolator scheduler.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package dsp_pkg;

    localparam int NV        = 8;    // voice count
    localparam int PW        = 14;   // pitch width
    localparam int STEP_LAST = 31;   // last step of a 32-step frame
    localparam int PH_W      = 12;   // per-voice phase accumulator width
    localparam int NEED_W    = 3;    // per-voice pending-sample counter width
    localparam int NEED_MAX  = 7;    // need counter saturates here

    // Net update of a need counter: add the accumulation carry, subtract a
    // grant, clamp to 0..NEED_MAX so it can neither wrap up nor underflow.
    function automatic logic [NEED_W-1:0] need_sat(
        input logic [NEED_W-1:0] cur,
        input logic [2:0]        add,
        input logic              dec
    );
        int t;
        t = int'(cur) + int'(add) - int'(dec);
        if (t > NEED_MAX) begin
            t = NEED_MAX;
        end else if (t < 0) begin
            t = 0;
        end
        return NEED_W'(t);
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Purpose: 8-way round-robin pick; search starts at ptr and wraps upward.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter_8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] gnt,
    output logic       gnt_vld
);

    logic [2:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// Purpose: 32-step frame sequencer, per-voice pitch accumulators and BRR fetch requests.
// Latency: request latched one cycle after need appears; next latch one cycle after a grant.
// Backpressure: req_valid/req_voice hold until req_ready, or until key_on kills the voice.
module interp_sched #(
    parameter int NV = dsp_pkg::NV,
    parameter int PW = dsp_pkg::PW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_en,
    input  logic [NV-1:0]         key_on,
    input  logic [NV-1:0][PW-1:0] pitch_x,
    output logic [4:0]            step,
    output logic                  exe_32khz,
    output logic [NV-1:0][7:0]    index_x,
    output logic                  req_valid,
    output logic [2:0]            req_voice,
    input  logic                  req_ready
);

    import dsp_pkg::*;

    // Sum width leaves room for carries 0..4 above the phase bits.
    localparam int SUM_W = PH_W + 3;

    logic [NV-1:0][PH_W-1:0]   ph;
    logic [NV-1:0][PH_W-1:0]   ph_nxt;
    logic [NV-1:0][NEED_W-1:0] need;
    logic [NV-1:0][NEED_W-1:0] need_nxt;
    logic [NV-1:0]             req_mask;
    logic [2:0]                rr_ptr;
    logic [2:0]                arb_gnt;
    logic                      arb_vld;
    logic                      acc_hit;
    logic [2:0]                acc_v;
    logic [SUM_W-1:0]          acc_sum;
    logic [2:0]                acc_add;
    logic                      hs_grant;
    logic                      hs_kill;

    rr_arbiter_8 u_arb (
        .req     (req_mask),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld)
    );

    // Frame strobe, accumulation slot and handshake outcome for this cycle.
    always_comb begin
        exe_32khz = cpu_en && (step == 5'(STEP_LAST));
        acc_hit   = cpu_en && (step[1:0] == 2'b11);
        acc_v     = step[4:2];
        acc_sum   = SUM_W'(ph[acc_v]) + SUM_W'(pitch_x[acc_v]);
        acc_add   = acc_sum[SUM_W-1:PH_W];
        hs_kill   = req_valid && key_on[req_voice];
        hs_grant  = req_valid && req_ready && !key_on[req_voice];
    end

    // Per-voice next state; key_on overrides both accumulation and grant.
    always_comb begin
        for (int v = 0; v < NV; v++) begin
            ph_nxt[v]   = ph[v];
            need_nxt[v] = need_sat(need[v],
                                   (acc_hit && acc_v == 3'(v)) ? acc_add : 3'd0,
                                   hs_grant && (req_voice == 3'(v)));
            if (acc_hit && acc_v == 3'(v)) begin
                ph_nxt[v] = acc_sum[PH_W-1:0];
            end
            if (key_on[v]) begin
                ph_nxt[v]   = '0;
                need_nxt[v] = '0;
            end
            // A voice being restarted this cycle is not a candidate.
            req_mask[v] = (need[v] != '0) && !key_on[v];
            index_x[v]  = ph[v][PH_W-1:PH_W-8];
        end
    end

    // Step counter advances only on enabled cycles and wraps 31 -> 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step <= '0;
        end else if (cpu_en) begin
            step <= step + 5'd1;
        end
    end

    // Phase and need registers for all voices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph   <= '0;
            need <= '0;
        end else begin
            ph   <= ph_nxt;
            need <= need_nxt;
        end
    end

    // Request latch: drop on grant or kill, otherwise latch the arbiter pick when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_valid <= 1'b0;
            req_voice <= '0;
            rr_ptr    <= '0;
        end else if (req_valid) begin
            if (hs_grant) begin
                req_valid <= 1'b0;
                rr_ptr    <= req_voice + 3'd1;
            end else if (hs_kill) begin
                req_valid <= 1'b0;
            end
        end else if (arb_vld) begin
            req_valid <= 1'b1;
            req_voice <= arb_gnt;
        end
    end

endmodule

// File: tb/tb_interp_sched.sv
module tb_interp_sched;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             cpu_en = 1'b0;
    logic [7:0]       key_on = '0;
    logic [7:0][13:0] pitch_x = '0;
    logic [4:0]       step;
    logic             exe_32khz;
    logic [7:0][7:0]  index_x;
    logic             req_valid;
    logic [2:0]       req_voice;
    logic             req_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    interp_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_en    (cpu_en),
        .key_on    (key_on),
        .pitch_x   (pitch_x),
        .step      (step),
        .exe_32khz (exe_32khz),
        .index_x   (index_x),
        .req_valid (req_valid),
        .req_voice (req_voice),
        .req_ready (req_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame position, phases, pending counts, request state.
    int m_step = 0;
    int m_ptr = 0;
    int m_rvoice = 0;
    bit m_rv = 0;
    int m_ph[8] = '{default: 0};
    int m_need[8] = '{default: 0};

    always @(posedge clk or negedge reset_n) begin
        int n_ph[8];
        int n_need[8];
        bit grant, kill, found;
        int tot, d, c;
        if (!reset_n) begin
            m_step = 0; m_ptr = 0; m_rvoice = 0; m_rv = 0;
            for (int v = 0; v < 8; v++) begin
                m_ph[v] = 0;
                m_need[v] = 0;
            end
        end else begin
            grant = m_rv && req_ready && !key_on[m_rvoice];
            kill  = m_rv && key_on[m_rvoice];
            for (int v = 0; v < 8; v++) begin
                n_ph[v] = m_ph[v];
                d = 0;
                if (cpu_en && m_step == 4 * v + 3) begin
                    tot = m_ph[v] + int'(pitch_x[v]);
                    n_ph[v] = tot % 4096;
                    d = tot / 4096;
                end
                if (grant && m_rvoice == v) d = d - 1;
                n_need[v] = m_need[v] + d;
                if (n_need[v] > 7) n_need[v] = 7;
                if (n_need[v] < 0) n_need[v] = 0;
                if (key_on[v]) begin
                    n_ph[v] = 0;
                    n_need[v] = 0;
                end
            end
            if (m_rv) begin
                if (grant) begin
                    m_rv = 0;
                    m_ptr = (m_rvoice + 1) % 8;
                end else if (kill) begin
                    m_rv = 0;
                end
            end else begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    c = (m_ptr + k) % 8;
                    if (!found && m_need[c] > 0 && !key_on[c]) begin
                        found = 1;
                        m_rv = 1;
                        m_rvoice = c;
                    end
                end
            end
            for (int v = 0; v < 8; v++) begin
                m_ph[v] = n_ph[v];
                m_need[v] = n_need[v];
            end
            if (cpu_en) m_step = (m_step + 1) % 32;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("step", 32'(step), m_step);
        chk("exe_32khz", 32'(exe_32khz), 32'(cpu_en && m_step == 31));
        chk("req_valid", 32'(req_valid), 32'(m_rv));
        chk("req_voice", 32'(req_voice), m_rvoice);
        for (int v = 0; v < 8; v++) chk("index_x", 32'(index_x[v]), m_ph[v] / 16);
    end

    // Grant observer.
    int gnt_cnt = 0;
    int gnt_q[$];
    always @(negedge clk) begin
        if (reset_n && req_valid && req_ready && !key_on[req_voice]) begin
            gnt_cnt++;
            gnt_q.push_back(int'(req_voice));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_en = 1'b0; key_on = '0; pitch_x = '0; req_ready = 1'b0;
        #1;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    int n_exe;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_step", 32'(step), 0);
        chk("rst_exe", 32'(exe_32khz), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_index", 32'(index_x), 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Free-running frames: exe once per 32 enabled cycles.
        cpu_en = 1'b1;
        n_exe = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (exe_32khz) begin
                n_exe++;
                chk("exe_at_31", 32'(step), 31);
            end
            @(posedge clk);
            #2;
        end
        chk("exe_count", n_exe, 2);
        chk("step_after_64", 32'(step), 0);

        // Saturating need with a stalled fetcher.
        do_reset();
        pitch_x[2] = 14'h1000; cpu_en = 1'b1;
        tick(256);
        chk("sat_req_valid", 32'(req_valid), 1);
        chk("sat_req_voice", 32'(req_voice), 2);
        chk("model_need2", m_need[2], 7);
        cpu_en = 1'b0; pitch_x = '0; gnt_cnt = 0; req_ready = 1'b1;
        tick(20);
        chk("sat_drain_grants", gnt_cnt, 7);
        chk("sat_drained_valid", 32'(req_valid), 0);

        // Half-rate pitch: index toggles 0x80/0x00, one grant every other frame.
        do_reset();
        pitch_x[0] = 14'h0800; cpu_en = 1'b1; req_ready = 1'b1; gnt_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            tick(5);
            chk("half_index0", 32'(index_x[0]), (f % 2 == 0) ? 32'h80 : 32'h00);
            tick(27);
        end
        chk("half_grants", gnt_cnt, 4);

        // Round-robin order with needs 1,2,1 on voices 1,5,6.
        do_reset();
        pitch_x[1] = 14'h1000; pitch_x[5] = 14'h2000; pitch_x[6] = 14'h1000;
        cpu_en = 1'b1;
        tick(32);
        cpu_en = 1'b0; pitch_x = '0;
        gnt_q.delete();
        req_ready = 1'b1;
        tick(12);
        chk("rr_count", gnt_q.size(), 4);
        if (gnt_q.size() == 4) begin
            chk("rr_g0", gnt_q[0], 1);
            chk("rr_g1", gnt_q[1], 5);
            chk("rr_g2", gnt_q[2], 6);
            chk("rr_g3", gnt_q[3], 5);
        end
        chk("rr_idle", 32'(req_valid), 0);

        // key_on kills a pending request on the same cycle as req_ready.
        do_reset();
        pitch_x[3] = 14'h1100; cpu_en = 1'b1;
        tick(32);
        cpu_en = 1'b0; pitch_x = '0;
        chk("kill_pre_voice", 32'(req_voice), 3);
        chk("kill_pre_valid", 32'(req_valid), 1);
        chk("kill_pre_index", 32'(index_x[3]), 32'h10);
        key_on = 8'h08; req_ready = 1'b1; gnt_cnt = 0;
        tick(1);
        key_on = '0;
        #1;
        chk("kill_valid", 32'(req_valid), 0);
        chk("kill_index", 32'(index_x[3]), 0);
        chk("kill_model_need", m_need[3], 0);
        tick(10);
        chk("kill_no_grant", gnt_cnt, 0);
        chk("kill_still_idle", 32'(req_valid), 0);

        // Randomized traffic, with an asynchronous reset dropped mid-frame.
        do_reset();
        for (int v = 0; v < 8; v++) begin
            case ($urandom_range(0, 3))
                0: pitch_x[v] = 14'h0000;
                1: pitch_x[v] = 14'h1000;
                2: pitch_x[v] = 14'h3FFF;
                default: pitch_x[v] = 14'($urandom_range(0, 16383));
            endcase
        end
        for (int i = 0; i < 3000; i++) begin
            cpu_en = ($urandom_range(0, 3) != 0);
            req_ready = ($urandom_range(0, 2) == 0);
            key_on = ($urandom_range(0, 40) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if (i % 500 == 499) pitch_x[$urandom_range(0, 7)] = 14'($urandom_range(0, 16383));
            if (i == 1500) begin
                #1 reset_n = 1'b0;
                #1;
                chk("mid_rst_step", 32'(step), 0);
                chk("mid_rst_exe", 32'(exe_32khz), 0);
                chk("mid_rst_valid", 32'(req_valid), 0);
                chk("mid_rst_voice", 32'(req_voice), 0);
                chk("mid_rst_index", 32'(index_x), 0);
                @(posedge clk);
                #2;
                reset_n = 1'b1;
                cpu_en = 1'b1; key_on = '0;
                #1;
                chk("post_rst_step0", 32'(step), 0);
                tick(1);
                chk("post_rst_step1", 32'(step), 1);
            end
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
